// File: rtl/hack_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the Hack program loader.
// The loader takes the slave view: it consumes the stream and drives the write port.
interface hack_prog_loader_if #(
  parameter int ADDR_W = 15
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/hack_prog_loader.sv
// Loads the Hack instruction memory at run time from a big-endian byte stream,
// holding the CPU in reset until the program is in place.
module hack_prog_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768,
  parameter int BOOT_HOLD = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  hack_prog_loader_if.slave   bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                err_odd,
  output logic                err_ovf,
  output logic [15:0]         word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
  localparam logic              HOLD      = (BOOT_HOLD != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] hi_byte;
  logic       last_seen;
  logic       xfer;

  assign xfer = bus.s_valid && bus.s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus.s_ready <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_odd     <= 1'b0;
      err_ovf     <= 1'b0;
      word_count  <= '0;
      cpu_reset   <= HOLD;
      last_seen   <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        // Idle or finished states: only a start pulse moves us; starts while busy fall through.
        IDLE, DONE, ERR: begin
          if (start) begin
            state       <= LOAD_HI;
            bus.s_ready <= 1'b1;
            bus.wr_addr <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            err_odd     <= 1'b0;
            err_ovf     <= 1'b0;
            word_count  <= '0;
            cpu_reset   <= 1'b1;
          end
        end
        LOAD_HI: begin
          if (xfer) begin
            hi_byte <= bus.s_data;
            if (bus.s_last) begin
              // Program ended on a high byte: pad the low half with zero.
              bus.wr_data <= {bus.s_data, 8'h00};
              bus.wr_en   <= 1'b1;
              bus.s_ready <= 1'b0;
              err_odd     <= 1'b1;
              last_seen   <= 1'b1;
              state       <= WRITE;
            end else begin
              last_seen <= 1'b0;
              state     <= LOAD_LO;
            end
          end
        end
        LOAD_LO: begin
          if (xfer) begin
            bus.wr_data <= {hi_byte, bus.s_data};
            bus.wr_en   <= 1'b1;
            bus.s_ready <= 1'b0;
            last_seen   <= bus.s_last;
            state       <= WRITE;
          end
        end
        WRITE: begin
          word_count <= word_count + 16'd1;
          if (last_seen) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= 1'b0;
          end else if (bus.wr_addr == LAST_ADDR) begin
            // Memory full and more data pending: stop rather than wrap the address.
            state     <= ERR;
            err_ovf   <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= HOLD;
          end else begin
            bus.wr_addr <= bus.wr_addr + 1'b1;
            bus.s_ready <= 1'b1;
            state       <= LOAD_HI;
          end
        end
        default: begin
          state       <= IDLE;
          bus.s_ready <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          cpu_reset   <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_prog_loader.sv
// Scoreboard bench for hack_prog_loader: unit 0 uses default parameters,
// unit 1 uses a 4-word memory with BOOT_HOLD=0.
module tb_hack_prog_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic mon_en = 1'b0;

  logic cpu_reset0, busy0, done0, err_odd0, err_ovf0;
  logic cpu_reset1, busy1, done1, err_odd1, err_ovf1;
  logic [15:0] word_count0, word_count1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  hack_prog_loader_if #(.ADDR_W(15)) bif0();
  hack_prog_loader_if #(.ADDR_W(15)) bif1();

  hack_prog_loader #(.ADDR_W(15), .MAX_WORDS(32768), .BOOT_HOLD(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .bus(bif0),
    .cpu_reset(cpu_reset0), .busy(busy0), .done(done0),
    .err_odd(err_odd0), .err_ovf(err_ovf0), .word_count(word_count0)
  );

  hack_prog_loader #(.ADDR_W(15), .MAX_WORDS(4), .BOOT_HOLD(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(bif1),
    .cpu_reset(cpu_reset1), .busy(busy1), .done(done1),
    .err_odd(err_odd1), .err_ovf(err_ovf1), .word_count(word_count1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write-port monitors: every wr_en must match the next expected word.
  always @(negedge clk) begin
    if (mon_en && bif0.wr_en) begin
      check_val("u0_sready_in_write", 32'(bif0.s_ready), 32'd0);
      if (q0.size() == 0)
        check_val("u0_unexpected_wr", 32'({bif0.wr_addr, bif0.wr_data}), 32'hFFFF_FFFF);
      else
        check_val("u0_wr", 32'({bif0.wr_addr, bif0.wr_data}), q0.pop_front());
    end
    if (mon_en && bif1.wr_en) begin
      check_val("u1_sready_in_write", 32'(bif1.s_ready), 32'd0);
      if (q1.size() == 0)
        check_val("u1_unexpected_wr", 32'({bif1.wr_addr, bif1.wr_data}), 32'hFFFF_FFFF);
      else
        check_val("u1_wr", 32'({bif1.wr_addr, bif1.wr_data}), q1.pop_front());
    end
  end

  // cpu_reset rules: BOOT_HOLD=1 releases exactly while done; BOOT_HOLD=0 follows busy.
  always @(negedge clk) begin
    if (mon_en && (busy0 || done0 || cpu_reset0 !== 1'b1))
      check_val("u0_cpu_reset", 32'(cpu_reset0), 32'(!done0));
    if (mon_en && (busy1 || cpu_reset1 !== 1'b0))
      check_val("u1_cpu_reset", 32'(cpu_reset1), 32'(busy1));
  end

  function automatic logic rdy(input int u);
    return (u == 0) ? bif0.s_ready : bif1.s_ready;
  endfunction

  function automatic logic is_done(input int u);
    return (u == 0) ? done0 : done1;
  endfunction

  task automatic set_in(input int u, input logic v, input logic [7:0] d, input logic l);
    if (u == 0) begin
      bif0.s_valid = v; bif0.s_data = d; bif0.s_last = l;
    end else begin
      bif1.s_valid = v; bif1.s_data = d; bif1.s_last = l;
    end
  endtask

  task automatic do_start(input int u);
    @(negedge clk);
    if (u == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (u == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic send_byte(input int u, input logic [7:0] d, input logic l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    set_in(u, 1'b1, d, l);
    n = 0;
    while (!rdy(u) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("sready_timeout", 32'(rdy(u)), 32'd1);
    @(posedge clk);
    #1;
    set_in(u, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic load_prog(input int u, input logic [7:0] b[$], input bit with_last, input int gap_max);
    for (int i = 0; i < b.size(); i++)
      send_byte(u, b[i], with_last && (i == b.size() - 1),
                (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  // Expected words: big-endian pairs, odd tail padded with 0x00, addresses from 0.
  task automatic exp_prog(input int u, input logic [7:0] b[$]);
    logic [14:0] a;
    logic [15:0] w;
    for (int i = 0; i < b.size(); i += 2) begin
      a = 15'(i / 2);
      w = {b[i], (i + 1 < b.size()) ? b[i + 1] : 8'h00};
      if (u == 0) q0.push_back(32'({a, w})); else q1.push_back(32'({a, w}));
    end
  endtask

  task automatic wait_done(input int u);
    int n;
    n = 0;
    while (!is_done(u) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("done_reached", 32'(is_done(u)), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    logic [7:0] pr[$];
    logic [7:0] pov[$];
    logic [7:0] p4[$];
    logic [7:0] pw[$];
    int hits;

    p1  = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    p2  = '{8'h00, 8'h10, 8'h7F};
    pr  = '{8'h12, 8'h34};
    pov = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    p4  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h17, 8'h28};
    pw  = '{8'hBE, 8'hEF};

    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_sready", 32'(bif0.s_ready), 32'd0);
    check_val("rst_wr_en", 32'(bif0.wr_en), 32'd0);
    check_val("rst_wr_addr", 32'(bif0.wr_addr), 32'd0);
    check_val("rst_wr_data", 32'(bif0.wr_data), 32'd0);
    check_val("rst_flags", 32'({busy0, done0, err_odd0, err_ovf0}), 32'd0);
    check_val("rst_word_count", 32'(word_count0), 32'd0);
    check_val("rst_cpu_reset_hold1", 32'(cpu_reset0), 32'd1);
    check_val("rst_cpu_reset_hold0", 32'(cpu_reset1), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic 2-word load
    do_start(0);
    check_val("start_busy", 32'(busy0), 32'd1);
    exp_prog(0, p1);
    load_prog(0, p1, 1'b1, 0);
    wait_done(0);
    check_val("t1_word_count", 32'(word_count0), 32'd2);
    check_val("t1_errs", 32'({err_odd0, err_ovf0}), 32'd0);
    check_val("t1_cpu_reset", 32'(cpu_reset0), 32'd0);
    check_val("t1_busy", 32'(busy0), 32'd0);

    // Odd length, restart from DONE
    do_start(0);
    exp_prog(0, p2);
    load_prog(0, p2, 1'b1, 0);
    wait_done(0);
    check_val("t2_err_odd", 32'(err_odd0), 32'd1);
    check_val("t2_word_count", 32'(word_count0), 32'd2);
    repeat (3) @(negedge clk);
    check_val("t2_err_odd_held", 32'(err_odd0), 32'd1);

    // Random gaps on the stream
    do_start(0);
    check_val("t3_err_odd_cleared", 32'(err_odd0), 32'd0);
    exp_prog(0, p1);
    load_prog(0, p1, 1'b1, 4);
    wait_done(0);
    check_val("t3_word_count", 32'(word_count0), 32'd2);

    // Reset in the middle of a load
    do_start(0);
    exp_prog(0, pr);
    send_byte(0, 8'h12, 1'b0, 0);
    send_byte(0, 8'h34, 1'b0, 0);
    send_byte(0, 8'hAB, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("t5_wr_en", 32'(bif0.wr_en), 32'd0);
    check_val("t5_wr_addr", 32'(bif0.wr_addr), 32'd0);
    check_val("t5_busy", 32'(busy0), 32'd0);
    check_val("t5_cpu_reset", 32'(cpu_reset0), 32'd1);
    check_val("t5_sready", 32'(bif0.s_ready), 32'd0);
    reset = 1'b0;
    do_start(0);
    exp_prog(0, p1);
    load_prog(0, p1, 1'b1, 1);
    wait_done(0);
    check_val("t5_word_count", 32'(word_count0), 32'd2);

    // Start mid-load is ignored; start in DONE restarts
    do_start(0);
    exp_prog(0, p1);
    send_byte(0, p1[0], 1'b0, 0);
    send_byte(0, p1[1], 1'b0, 0);
    do_start(0);
    send_byte(0, p1[2], 1'b0, 0);
    send_byte(0, p1[3], 1'b1, 0);
    wait_done(0);
    check_val("t6_word_count", 32'(word_count0), 32'd2);
    do_start(0);
    check_val("t6_restart_count", 32'(word_count0), 32'd0);
    check_val("t6_restart_done", 32'(done0), 32'd0);
    exp_prog(0, pw);
    load_prog(0, pw, 1'b1, 0);
    wait_done(0);
    check_val("t6_one_word", 32'(word_count0), 32'd1);

    // Overflow on the 4-word unit
    do_start(1);
    exp_prog(1, pov);
    load_prog(1, pov, 1'b0, 0);
    set_in(1, 1'b1, 8'h09, 1'b0);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (bif1.s_ready) hits++;
    end
    set_in(1, 1'b0, 8'h00, 1'b0);
    check_val("t4_sready_in_err", 32'(hits), 32'd0);
    check_val("t4_err_ovf", 32'(err_ovf1), 32'd1);
    check_val("t4_done", 32'(done1), 32'd0);
    check_val("t4_word_count", 32'(word_count1), 32'd4);
    check_val("t4_cpu_reset", 32'(cpu_reset1), 32'd0);

    // Last byte lands on the final address: DONE, not ERR
    do_start(1);
    check_val("t4b_ovf_cleared", 32'(err_ovf1), 32'd0);
    exp_prog(1, p4);
    load_prog(1, p4, 1'b1, 2);
    wait_done(1);
    check_val("t4b_err_ovf", 32'(err_ovf1), 32'd0);
    check_val("t4b_word_count", 32'(word_count1), 32'd4);

    repeat (3) @(negedge clk);
    check_val("q0_drained", 32'(q0.size()), 32'd0);
    check_val("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
